result_unloader: RTL and testbench

//  Downstream stage of the block-sum FSM. After the FSM pulses ready, this block
//  re-reads the 5 block sums (addr 4,9,14,19,24) and the grand total (addr 31)

---
 rtl/result_unloader_pkg.sv | 32 +++
 rtl/result_unloader.sv | 110 +++++++++++
 tb/tb_result_unloader.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/result_unloader_pkg.sv
// Shared constants for the result unloader: word widths, the block-sum memory map
// and the sequencer state encoding.
package result_unloader_pkg;

  localparam int DATA_W       = 16;
  localparam int ADDR_W       = 5;
  localparam int INDEX_W      = 3;
  localparam int NUM_BLOCKS   = 5;
  localparam int BLOCK_STRIDE = 5;
  localparam int RESULT_OFS   = 4;
  localparam int TOTAL_ADDR   = 31;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CAP   = 3'd3,
    ST_SEND  = 3'd4,
    ST_CHECK = 3'd5
  } state_t;

  // Indices below NUM_BLOCKS select a block sum; the one after them is the grand total.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [INDEX_W-1:0] idx);
    logic [ADDR_W-1:0] addr;
    if (idx < INDEX_W'(NUM_BLOCKS))
      addr = ADDR_W'(int'(idx) * BLOCK_STRIDE + RESULT_OFS);
    else
      addr = ADDR_W'(TOTAL_ADDR);
    return addr;
  endfunction

endpackage

// File: rtl/result_unloader.sv
// Re-reads the block sums and grand total after the block-sum FSM finishes,
// streams them over a valid/ready port and flags a stored-total mismatch.
module result_unloader
  import result_unloader_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sum_ready,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read_en,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [2:0]        out_index,
  output logic              out_last,
  output logic              check_error,
  output logic              done
);

  state_t              state;
  logic [INDEX_W-1:0]  index;
  logic [DATA_W-1:0]   acc;
  logic [DATA_W-1:0]   total;
  logic                sum_ready_prev;
  logic                start;
  logic                last_word;
  logic [ADDR_W-1:0]   next_addr;

  assign start     = sum_ready & ~sum_ready_prev;
  assign last_word = (index == INDEX_W'(NUM_BLOCKS));

  always_comb begin
    next_addr = word_addr(index);
  end

  // acc wraps mod 2^DATA_W on purpose, matching the upstream total register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      index          <= '0;
      acc            <= '0;
      total          <= '0;
      sum_ready_prev <= 1'b0;
      mem_req        <= 1'b0;
      mem_address    <= '0;
      mem_read_en    <= 1'b0;
      out_valid      <= 1'b0;
      out_data       <= '0;
      out_index      <= '0;
      out_last       <= 1'b0;
      check_error    <= 1'b0;
      done           <= 1'b0;
    end else begin
      sum_ready_prev <= sum_ready;
      done           <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state       <= ST_REQ;
            mem_req     <= 1'b1;
            index       <= '0;
            acc         <= '0;
            total       <= '0;
            check_error <= 1'b0;
          end
        end
        ST_REQ: begin
          if (mem_gnt) begin
            mem_address <= next_addr;
            mem_read_en <= 1'b1;
            state       <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          mem_read_en <= 1'b0;
          state       <= ST_CAP;
        end
        ST_CAP: begin
          out_data  <= mem_data_out;
          out_index <= index;
          out_valid <= 1'b1;
          out_last  <= last_word;
          if (last_word)
            total <= mem_data_out;
          else
            acc <= acc + mem_data_out;
          state <= ST_SEND;
        end
        ST_SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            index     <= index + 1'b1;
            state     <= last_word ? ST_CHECK : ST_REQ;
          end
        end
        ST_CHECK: begin
          check_error <= (acc != total);
          done        <= 1'b1;
          mem_req     <= 1'b0;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_unloader.sv
// Directed bench for result_unloader: a synchronous-read memory model plus
// linear scenarios with hand-computed streams and checker results.
module tb_result_unloader;
  import result_unloader_pkg::*;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              sum_ready;
  logic              mem_req;
  logic              mem_gnt;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_read_en;
  logic [DATA_W-1:0] mem_data_out;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [2:0]        out_index;
  logic              out_last;
  logic              check_error;
  logic              done;

  logic [DATA_W-1:0] mem [0:31];
  logic [DATA_W-1:0] exp_blk [0:4];
  logic [DATA_W-1:0] exp_total;

  logic [DATA_W-1:0] got_data [$];
  logic [2:0]        got_idx  [$];
  logic              got_last [$];
  int done_count;
  int read_count;
  int overlap_count;

  int total_checks = 0;
  int bad_checks   = 0;

  always #5 clk = ~clk;

  result_unloader dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sum_ready    (sum_ready),
    .mem_req      (mem_req),
    .mem_gnt      (mem_gnt),
    .mem_address  (mem_address),
    .mem_read_en  (mem_read_en),
    .mem_data_out (mem_data_out),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_index    (out_index),
    .out_last     (out_last),
    .check_error  (check_error),
    .done         (done)
  );

  // Memory returns data the cycle after the read strobe.
  always @(posedge clk) begin
    if (mem_read_en) mem_data_out <= mem[mem_address];
  end

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      got_data.push_back(out_data);
      got_idx.push_back(out_index);
      got_last.push_back(out_last);
    end
    if (done) done_count++;
    if (mem_read_en) read_count++;
    if (done && out_valid) overlap_count++;
  end

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total_checks++;
    assert (observed === expected) else begin
      bad_checks++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic set_mem(input logic [15:0] b0, input logic [15:0] b1, input logic [15:0] b2,
                         input logic [15:0] b3, input logic [15:0] b4, input logic [15:0] tot);
    for (int i = 0; i < 32; i++) mem[i] = 16'h0;
    mem[4]  = b0; mem[9]  = b1; mem[14] = b2; mem[19] = b3; mem[24] = b4; mem[31] = tot;
    exp_blk[0] = b0; exp_blk[1] = b1; exp_blk[2] = b2; exp_blk[3] = b3; exp_blk[4] = b4;
    exp_total = tot;
  endtask

  task automatic clear_capture();
    got_data.delete();
    got_idx.delete();
    got_last.delete();
    done_count    = 0;
    read_count    = 0;
    overlap_count = 0;
  endtask

  task automatic apply_stimulus();
    sum_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    sum_ready = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_output(tag, 32'(done), 32'd1);
  endtask

  task automatic wait_index(input logic [2:0] idx, input string tag);
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(out_valid && out_index == idx) && n < 200);
    check_output(tag, 32'(out_valid && out_index == idx), 32'd1);
  endtask

  task automatic check_stream(input string tag);
    logic [15:0] want;
    check_output({tag, " count"}, 32'(got_data.size()), 32'd6);
    for (int i = 0; i < got_data.size() && i < 6; i++) begin
      want = (i < 5) ? exp_blk[i] : exp_total;
      check_output($sformatf("%s data%0d", tag, i), 32'(got_data[i]), 32'(want));
      check_output($sformatf("%s idx%0d", tag, i), 32'(got_idx[i]), 32'(i));
      check_output($sformatf("%s last%0d", tag, i), 32'(got_last[i]), 32'(i == 5));
    end
    check_output({tag, " done_pulses"}, 32'(done_count), 32'd1);
    check_output({tag, " done_overlap"}, 32'(overlap_count), 32'd0);
    check_output({tag, " reads"}, 32'(read_count), 32'd6);
  endtask

  function automatic logic [31:0] all_outputs();
    return 32'({mem_req, mem_read_en, mem_address, out_valid, out_data,
                out_index, out_last, check_error, done});
  endfunction

  initial begin
    int stable;
    int rc0;
    int req_ok;

    reset_n      = 1'b0;
    sum_ready    = 1'b0;
    mem_gnt      = 1'b1;
    out_ready    = 1'b1;
    mem_data_out = '0;
    set_mem(16'd10, 16'd20, 16'd30, 16'd40, 16'd50, 16'd150);
    clear_capture();
    repeat (3) @(posedge clk);
    #1;
    check_output("reset outputs", all_outputs(), 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] scenario 1: matching total");
    clear_capture();
    sum_ready = 1'b1;
    @(posedge clk); #1;
    check_output("t1 req after start", 32'(mem_req), 32'd1);
    @(posedge clk); #1;
    sum_ready = 1'b0;
    check_output("t1 first addr", 32'(mem_address), 32'd4);
    check_output("t1 first read_en", 32'(mem_read_en), 32'd1);
    @(posedge clk); #1;
    check_output("t1 valid edge3", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check_output("t1 valid edge4", 32'(out_valid), 32'd1);
    check_output("t1 first data", 32'(out_data), 32'd10);
    wait_done("t1 done");
    check_output("t1 check_error", 32'(check_error), 32'd0);
    check_output("t1 req released", 32'(mem_req), 32'd0);
    @(posedge clk); #1;
    check_stream("t1");

    $display("[TB] scenario 2: mismatching total");
    set_mem(16'd10, 16'd20, 16'd30, 16'd40, 16'd50, 16'd151);
    clear_capture();
    apply_stimulus();
    wait_done("t2 done");
    check_output("t2 check_error", 32'(check_error), 32'd1);
    repeat (4) @(posedge clk);
    #1;
    check_output("t2 check_error held", 32'(check_error), 32'd1);
    check_stream("t2");

    $display("[TB] scenario 3: downstream stall on index 2");
    set_mem(16'd10, 16'd20, 16'd30, 16'd40, 16'd50, 16'd150);
    clear_capture();
    apply_stimulus();
    check_output("t3 start clears error", 32'(check_error), 32'd0);
    wait_index(3'd2, "t3 reach idx2");
    out_ready = 1'b0;
    rc0 = read_count;
    stable = 0;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      if (out_valid && out_data == 16'd30 && out_index == 3'd2 && !out_last) stable++;
    end
    check_output("t3 stall stable", 32'(stable), 32'd7);
    check_output("t3 no read in stall", 32'(read_count - rc0), 32'd0);
    out_ready = 1'b1;
    wait_done("t3 done");
    check_output("t3 check_error", 32'(check_error), 32'd0);
    @(posedge clk); #1;
    check_stream("t3");

    $display("[TB] scenario 4: wrapping sum");
    set_mem(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFB);
    clear_capture();
    apply_stimulus();
    wait_done("t4 done");
    check_output("t4 check_error", 32'(check_error), 32'd0);
    @(posedge clk); #1;
    check_stream("t4");

    $display("[TB] scenario 5: grant withheld, repeat start ignored");
    set_mem(16'd10, 16'd20, 16'd30, 16'd40, 16'd50, 16'd150);
    clear_capture();
    mem_gnt = 1'b0;
    apply_stimulus();
    req_ok = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 2) sum_ready = 1'b1;
      if (i == 4) sum_ready = 1'b0;
      @(posedge clk); #1;
      if (mem_req && !mem_read_en) req_ok++;
    end
    check_output("t5 req without read", 32'(req_ok), 32'd10);
    check_output("t5 no reads", 32'(read_count), 32'd0);
    mem_gnt = 1'b1;
    wait_done("t5 done");
    repeat (10) @(posedge clk);
    #1;
    check_output("t5 idle after run", 32'(mem_req), 32'd0);
    check_stream("t5");

    $display("[TB] scenario 6: reset during index 3");
    clear_capture();
    apply_stimulus();
    wait_index(3'd3, "t6 reach idx3");
    reset_n = 1'b0;
    #1;
    check_output("t6 reset outputs", all_outputs(), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    clear_capture();
    apply_stimulus();
    wait_done("t6 done");
    @(posedge clk); #1;
    check_output("t6 restart data", 32'(got_data.size() > 0 ? got_data[0] : 16'hDEAD), 32'd10);
    check_stream("t6");

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
